// File: rtl/tape_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tape_pkg
//  Description : Shared types and constants for the cassette tape player.
//                Holds the fetch/shift state encodings and the SDRAM byte
//                address width.
//  Revision    : 1.0 - initial release
// ============================================================================
package tape_pkg;

    localparam int TAPE_AW = 25;

    typedef enum logic [0:0] {
        F_IDLE = 1'b0,
        F_REQ  = 1'b1
    } fetch_state_t;

    typedef enum logic [2:0] {
        S_STOP  = 3'd0,
        S_LOAD  = 3'd1,
        S_HALF1 = 3'd2,
        S_HALF2 = 3'd3,
        S_END   = 3'd4
    } shift_state_t;

endpackage
`default_nettype wire

// File: rtl/tape_player_if.sv
`default_nettype none
// ============================================================================
//  Module      : tape_player_if
//  Description : Byte-fetch port between the tape player and the SDRAM
//                arbiter.
//                mem_req  - fetch request, held until mem_ack
//                mem_addr - byte address, stable while mem_req is high
//                mem_ack  - one-cycle strobe, mem_data valid in that cycle
//                mem_data - fetched byte
//  Revision    : 1.0 - initial release
// ============================================================================
interface tape_player_if;
    import tape_pkg::*;

    logic               mem_req;
    logic [TAPE_AW-1:0] mem_addr;
    logic               mem_ack;
    logic [7:0]         mem_data;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);

endinterface
`default_nettype wire

// File: rtl/tape_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : tape_fifo2
//  Description : Two-entry, 8-bit prefetch FIFO.
//                clk_sys/reset - clock, synchronous active-high reset
//                flush         - synchronous empty
//                push/din      - write a byte (ignored when full unless popping)
//                pop           - discard head (ignored when empty)
//                dout          - head byte, count - bytes held (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module tape_fifo2
    import tape_pkg::*;
(
    input  wire        clk_sys,
    input  wire        reset,
    input  wire        flush,
    input  wire        push,
    input  wire        pop,
    input  wire  [7:0] din,
    output logic [7:0] dout,
    output logic [1:0] count
);

    logic [7:0] r_mem [2];
    logic       r_rd;
    logic       r_wr;
    logic [1:0] r_count;
    logic       w_push_ok;
    logic       w_pop_ok;

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign w_pop_ok  = pop && (r_count != 2'd0);
    assign w_push_ok = push && ((r_count != 2'd2) || w_pop_ok);

    always_ff @(posedge clk_sys) begin
        if (reset || flush) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr] <= din;
                r_wr        <= ~r_wr;
            end
            if (w_pop_ok) begin
                r_rd <= ~r_rd;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/tape_player.sv
`default_nettype none
// ============================================================================
//  Module      : tape_player
//  Description : Streams a tape image from SDRAM as a biphase bit stream.
//                Each bit (MSB first) is sent as ~bit for HALF_PERIOD cycles
//                followed by bit for HALF_PERIOD cycles.
//                clk_sys/reset - clock, synchronous active-high reset
//                play          - level: 1 run, 0 pause
//                rewind        - pulse: restart from tape byte 0
//                tape_size     - image length in bytes
//                mem           - byte-fetch port (master side)
//                tapein        - tape signal, active - shifting, done - end of tape
//  Revision    : 1.0 - initial release
// ============================================================================
module tape_player
    import tape_pkg::*;
#(
    parameter int                 HALF_PERIOD = 4800,
    parameter logic [TAPE_AW-1:0] BASE_ADDR   = 25'h180000
) (
    input  wire                clk_sys,
    input  wire                reset,
    input  wire                play,
    input  wire                rewind,
    input  wire  [TAPE_AW-1:0] tape_size,
    tape_player_if.master      mem,
    output logic               tapein,
    output logic               active,
    output logic               done
);

    localparam int                 c_CNT_W    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(HALF_PERIOD - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [TAPE_AW-1:0] c_POS_ONE  = TAPE_AW'(1);

    fetch_state_t       r_fstate, w_fstate_nxt;
    shift_state_t       r_sstate, w_sstate_nxt;
    logic [TAPE_AW-1:0] r_fetch_pos, w_fetch_pos_nxt;
    logic [TAPE_AW-1:0] r_play_pos, w_play_pos_nxt;
    logic [TAPE_AW-1:0] r_size, w_size_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic [2:0]         r_bit, w_bit_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_tapein, w_tapein_nxt;
    logic               r_done, w_done_nxt;

    logic [TAPE_AW-1:0] w_size;
    logic [TAPE_AW-1:0] w_play_inc;
    logic [2:0]         w_bit_dec;
    logic               w_push;
    logic               w_pop;
    logic [7:0]         w_fifo_dout;
    logic [1:0]         w_fifo_count;

    tape_fifo2 u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .flush   (rewind),
        .push    (w_push),
        .pop     (w_pop),
        .din     (mem.mem_data),
        .dout    (w_fifo_dout),
        .count   (w_fifo_count)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_fstate    <= F_IDLE;
            r_sstate    <= S_STOP;
            r_fetch_pos <= '0;
            r_play_pos  <= '0;
            r_size      <= '0;
            r_shift     <= '0;
            r_bit       <= '0;
            r_cnt       <= '0;
            r_tapein    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_fstate    <= w_fstate_nxt;
            r_sstate    <= w_sstate_nxt;
            r_fetch_pos <= w_fetch_pos_nxt;
            r_play_pos  <= w_play_pos_nxt;
            r_size      <= w_size_nxt;
            r_shift     <= w_shift_nxt;
            r_bit       <= w_bit_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tapein    <= w_tapein_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        // tape_size is live while stopped and frozen once playback starts.
        w_size          = (r_sstate == S_STOP) ? tape_size : r_size;
        w_size_nxt      = w_size;
        w_play_inc      = r_play_pos + c_POS_ONE;
        w_bit_dec       = r_bit - 3'd1;
        w_fstate_nxt    = r_fstate;
        w_sstate_nxt    = r_sstate;
        w_fetch_pos_nxt = r_fetch_pos;
        w_play_pos_nxt  = r_play_pos;
        w_shift_nxt     = r_shift;
        w_bit_nxt       = r_bit;
        w_cnt_nxt       = r_cnt;
        w_tapein_nxt    = r_tapein;
        w_done_nxt      = r_done;
        w_push          = 1'b0;
        w_pop           = 1'b0;

        case (r_fstate)
            F_IDLE: begin
                if ((w_fifo_count < 2'd2) && (r_fetch_pos < w_size)) begin
                    w_fstate_nxt = F_REQ;
                end
            end
            F_REQ: begin
                if (mem.mem_ack) begin
                    w_push          = 1'b1;
                    w_fetch_pos_nxt = r_fetch_pos + c_POS_ONE;
                    w_fstate_nxt    = F_IDLE;
                end
            end
            default: w_fstate_nxt = F_IDLE;
        endcase

        case (r_sstate)
            S_STOP: begin
                if (play && !r_done) begin
                    if (w_size == '0) begin
                        w_sstate_nxt = S_END;
                        w_done_nxt   = 1'b1;
                        w_tapein_nxt = 1'b0;
                    end else begin
                        w_sstate_nxt = S_LOAD;
                    end
                end
            end
            // Waits here on underrun; tapein keeps its last level.
            S_LOAD: begin
                if (w_fifo_count != 2'd0) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_fifo_dout;
                    w_bit_nxt    = 3'd7;
                    w_cnt_nxt    = '0;
                    w_tapein_nxt = ~w_fifo_dout[7];
                    w_sstate_nxt = S_HALF1;
                end
            end
            S_HALF1: begin
                if (play) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_cnt_nxt    = '0;
                        w_tapein_nxt = r_shift[r_bit];
                        w_sstate_nxt = S_HALF2;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
            end
            S_HALF2: begin
                if (play) begin
                    if (r_cnt != c_CNT_LAST) begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end else if (r_bit != 3'd0) begin
                        w_cnt_nxt    = '0;
                        w_bit_nxt    = w_bit_dec;
                        w_tapein_nxt = ~r_shift[w_bit_dec];
                        w_sstate_nxt = S_HALF1;
                    end else begin
                        w_cnt_nxt      = '0;
                        w_play_pos_nxt = w_play_inc;
                        if (w_play_inc == r_size) begin
                            w_sstate_nxt = S_END;
                            w_done_nxt   = 1'b1;
                            w_tapein_nxt = 1'b0;
                        end else if (w_fifo_count != 2'd0) begin
                            // Load the next byte in this same cycle so byte
                            // boundaries carry no gap.
                            w_pop        = 1'b1;
                            w_shift_nxt  = w_fifo_dout;
                            w_bit_nxt    = 3'd7;
                            w_tapein_nxt = ~w_fifo_dout[7];
                            w_sstate_nxt = S_HALF1;
                        end else begin
                            w_sstate_nxt = S_LOAD;
                        end
                    end
                end
            end
            S_END: begin
                w_sstate_nxt = S_STOP;
            end
            default: w_sstate_nxt = S_STOP;
        endcase

        // Rewind overrides everything, including an ack in the same cycle.
        if (rewind) begin
            w_fstate_nxt    = F_IDLE;
            w_sstate_nxt    = S_STOP;
            w_fetch_pos_nxt = '0;
            w_play_pos_nxt  = '0;
            w_size_nxt      = tape_size;
            w_cnt_nxt       = '0;
            w_tapein_nxt    = 1'b0;
            w_done_nxt      = 1'b0;
            w_push          = 1'b0;
            w_pop           = 1'b0;
        end
    end

    assign mem.mem_req  = (r_fstate == F_REQ);
    assign mem.mem_addr = BASE_ADDR + r_fetch_pos;
    assign tapein       = r_tapein;
    assign done         = r_done;
    assign active       = (r_sstate == S_LOAD) || (r_sstate == S_HALF1) || (r_sstate == S_HALF2);

endmodule
`default_nettype wire

// File: tb/tb_tape_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tape_player
//  Description : Self-checking bench for tape_player with HALF_PERIOD = 4.
//                A byte-timeline reference model predicts every output each
//                cycle; directed scenarios add hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tape_player;
    import tape_pkg::*;

    localparam int          HP   = 4;
    localparam int          CELL = 16 * HP;          // cycles per byte
    localparam logic [24:0] BASE = 25'h180000;
    localparam int ST_STOP = 0, ST_LOAD = 1, ST_RUN = 2, ST_END = 3;

    logic        clk_sys = 1'b0;
    logic        reset, play, rewind;
    logic [24:0] tape_size;
    logic        tapein, active, done;

    tape_player_if mem_bus ();

    tape_player #(.HALF_PERIOD(HP), .BASE_ADDR(BASE)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .play      (play),
        .rewind    (rewind),
        .tape_size (tape_size),
        .mem       (mem_bus.master),
        .tapein    (tapein),
        .active    (active),
        .done      (done)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  img [8];
    int          lat;
    bit          man;
    int          wcnt;
    logic [24:0] acked_addr [$];

    // Reference model: byte-level playback timeline.
    bit          m_valid = 1'b0;
    int          m_q, m_fetched, m_popped, m_played, m_st, m_t;
    bit          m_req, m_done, m_tin;
    logic [7:0]  m_cur;
    logic [24:0] m_size;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    endtask

    // Level of tapein at cycle t (0..CELL-1) of byte b.
    function automatic bit wave(input logic [7:0] b, input int t);
        int bi;
        bi = 7 - t / (2 * HP);
        return ((t / HP) % 2 == 1) ? b[bi] : ~b[bi];
    endfunction

    task automatic model_step();
        logic [24:0] sz;
        bit          push, pop, req_n;
        if (reset) begin
            m_valid = 1'b1; m_q = 0; m_fetched = 0; m_popped = 0; m_played = 0;
            m_st = ST_STOP; m_t = 0; m_req = 1'b0; m_done = 1'b0; m_tin = 1'b0;
            m_cur = 8'h00; m_size = '0;
        end else if (m_valid && rewind) begin
            m_q = 0; m_fetched = 0; m_popped = 0; m_played = 0; m_st = ST_STOP;
            m_req = 1'b0; m_done = 1'b0; m_tin = 1'b0; m_size = tape_size;
        end else if (m_valid) begin
            sz   = (m_st == ST_STOP) ? tape_size : m_size;
            push = m_req && mem_bus.mem_ack;
            pop  = 1'b0;
            if (m_req) req_n = !mem_bus.mem_ack;
            else       req_n = (m_q < 2) && (m_fetched < int'(sz));
            case (m_st)
                ST_STOP: if (play && !m_done) begin
                    if (sz == '0) begin m_st = ST_END; m_done = 1'b1; m_tin = 1'b0; end
                    else m_st = ST_LOAD;
                end
                ST_LOAD: if (m_q > 0) begin
                    pop = 1'b1; m_cur = img[m_popped]; m_popped++; m_t = 0;
                    m_tin = ~m_cur[7]; m_st = ST_RUN;
                end
                ST_RUN: if (play) begin
                    if (m_t == CELL - 1) begin
                        m_played++;
                        if (m_played == int'(sz)) begin m_st = ST_END; m_done = 1'b1; m_tin = 1'b0; end
                        else if (m_q > 0) begin
                            pop = 1'b1; m_cur = img[m_popped]; m_popped++; m_t = 0; m_tin = ~m_cur[7];
                        end else m_st = ST_LOAD;
                    end else begin
                        m_t++; m_tin = wave(m_cur, m_t);
                    end
                end
                default: m_st = ST_STOP;
            endcase
            m_req = req_n;
            if (push) m_fetched++;
            m_q = m_q + int'(push) - int'(pop);
            m_size = sz;
        end
    endtask

    task automatic compare();
        if (!m_valid) return;
        check("tapein", 32'(tapein), 32'(m_tin));
        check("active", 32'(active), 32'((m_st == ST_LOAD) || (m_st == ST_RUN)));
        check("done", 32'(done), 32'(m_done));
        check("mem_req", 32'(mem_bus.mem_req), 32'(m_req));
        if (m_req) check("mem_addr", 32'(mem_bus.mem_addr), 32'(BASE + 25'(m_fetched)));
    endtask

    task automatic respond();
        logic [24:0] off;
        if (!man) begin
            if (mem_bus.mem_ack) mem_bus.mem_ack = 1'b0;
            else if (mem_bus.mem_req) begin
                if (wcnt >= lat) begin
                    off = mem_bus.mem_addr - BASE;
                    mem_bus.mem_ack  = 1'b1;
                    mem_bus.mem_data = img[off[2:0]];
                    acked_addr.push_back(mem_bus.mem_addr);
                    wcnt = 0;
                end else wcnt++;
            end else wcnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_step();
        #1;
        compare();
        @(negedge clk_sys);
        respond();
    endtask

    task automatic do_reset(input logic [24:0] size);
        reset = 1'b1; play = 1'b0; rewind = 1'b0; tape_size = size;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_data = 8'h00; man = 1'b0; wcnt = 0;
        acked_addr.delete();
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tapein"}, 32'(tapein), 32'd0);
        check({tag, "_active"}, 32'(active), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_mem_req"}, 32'(mem_bus.mem_req), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_bus.mem_addr), 32'h180000);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] pat;
        int done_at, first_hi, bad, gaps, first_act, req_cnt;
        bit seen_act, paused_lvl;

        for (int i = 0; i < 8; i++) img[i] = 8'h00;
        lat = 3;

        // Single byte A5, buffer prefilled before play.
        img[0] = 8'hA5;
        do_reset(25'd1);
        check_reset_values("reset");
        repeat (10) tick();
        play = 1'b1;
        pat = 16'b0110_0110_1001_1001;
        bad = 0; done_at = -1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (k >= 2 && k <= 65 && tapein !== pat[15 - (k - 2) / HP]) bad++;
            if (done === 1'b1 && done_at < 0) done_at = k;
        end
        check("a5_pattern_errors", 32'(bad), 32'd0);
        check("a5_done_cycle", 32'(done_at), 32'd66);
        check("a5_tapein_after_end", 32'(tapein), 32'd0);

        // Slow ack, three bytes back to back.
        img[0] = 8'h00; img[1] = 8'hFF; img[2] = 8'h55; lat = 20;
        do_reset(25'd3);
        play = 1'b1;
        first_hi = -1; done_at = -1;
        for (int k = 1; k <= 400 && done_at < 0; k++) begin
            tick();
            if (tapein === 1'b1 && first_hi < 0) first_hi = k;
            if (done === 1'b1) done_at = k;
        end
        check("slow_stream_length", 32'(done_at - first_hi), 32'd192);
        check("slow_fetch_count", 32'(acked_addr.size()), 32'd3);
        if (acked_addr.size() == 3) begin
            check("slow_addr0", 32'(acked_addr[0]), 32'h180000);
            check("slow_addr1", 32'(acked_addr[1]), 32'h180001);
            check("slow_addr2", 32'(acked_addr[2]), 32'h180002);
        end

        // Underrun: long fetch latency stalls between bytes.
        img[0] = 8'hC3; img[1] = 8'h3C; lat = 100;
        do_reset(25'd2);
        play = 1'b1;
        seen_act = 1'b0; gaps = 0; done_at = -1; first_act = -1;
        for (int k = 1; k <= 600 && done_at < 0; k++) begin
            tick();
            if (done === 1'b1) done_at = k;
            else if (active === 1'b1) begin
                if (!seen_act) first_act = k;
                seen_act = 1'b1;
            end else if (seen_act) gaps++;
        end
        check("underrun_done_seen", 32'(done_at > 0), 32'd1);
        check("underrun_active_gaps", 32'(gaps), 32'd0);
        check("underrun_stalled", 32'((done_at - first_act) > 2 * CELL), 32'd1);

        // Pause 37 cycles inside the first half of bit index 3.
        img[0] = 8'hA5; lat = 3;
        do_reset(25'd1);
        repeat (10) tick();
        play = 1'b1;
        done_at = -1; paused_lvl = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            tick();
            if (k == 36) play = 1'b0;
            if (k == 60) paused_lvl = tapein;
            if (k == 73) play = 1'b1;
            if (done === 1'b1 && done_at < 0) done_at = k;
        end
        check("pause_level_held", 32'(paused_lvl), 32'd1);
        check("pause_done_cycle", 32'(done_at), 32'd103);

        // Rewind while a request is outstanding, ack in the same cycle.
        img[0] = 8'h5A; img[1] = 8'h81;
        do_reset(25'd2);
        man = 1'b1;
        for (int k = 0; k < 10 && mem_bus.mem_req !== 1'b1; k++) tick();
        check("rw_req_seen", 32'(mem_bus.mem_req), 32'd1);
        rewind = 1'b1; mem_bus.mem_ack = 1'b1; mem_bus.mem_data = 8'hEE;
        tick();
        rewind = 1'b0; mem_bus.mem_ack = 1'b0;
        check("rw_req_dropped", 32'(mem_bus.mem_req), 32'd0);
        tick();
        check("rw_req_again", 32'(mem_bus.mem_req), 32'd1);
        check("rw_addr_restart", 32'(mem_bus.mem_addr), 32'h180000);
        man = 1'b0; lat = 2; wcnt = 0; play = 1'b1;
        done_at = -1;
        for (int k = 1; k <= 300 && done_at < 0; k++) begin
            tick();
            if (done === 1'b1) done_at = k;
        end
        check("rw_done_seen", 32'(done_at > 0), 32'd1);

        // Empty tape.
        do_reset(25'd0);
        play = 1'b1;
        req_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (mem_bus.mem_req === 1'b1) req_cnt++;
        end
        check("empty_req_count", 32'(req_cnt), 32'd0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_active", 32'(active), 32'd0);

        // Reset in the middle of a byte.
        img[0] = 8'hA5; lat = 3;
        do_reset(25'd1);
        repeat (10) tick();
        play = 1'b1;
        repeat (30) tick();
        check("midbyte_active", 32'(active), 32'd1);
        reset = 1'b1;
        tick();
        check_reset_values("midreset");
        reset = 1'b0; play = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
